// File: rtl/fg_bd_arbiter.sv
// Round-robin merge of per-flow burst descriptors into one registered
// descriptor stream, tagged with the index of the source that supplied it.
module fg_bd_arbiter #(
   parameter int PORTS      = 4,
   parameter int PORT_WIDTH = 2,
   parameter int DEST_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PORTS-1:0]           input_bd_valid,
   output logic [PORTS-1:0]           input_bd_ready,
   input  logic [PORTS*DEST_WIDTH-1:0] input_bd_dest,
   input  logic [PORTS*32-1:0]        input_bd_burst_len,
   output logic                       output_bd_valid,
   input  logic                       output_bd_ready,
   output logic [DEST_WIDTH-1:0]      output_bd_dest,
   output logic [31:0]                output_bd_burst_len,
   output logic [PORT_WIDTH-1:0]      output_bd_port,
   input  logic [PORTS-1:0]           port_enable,
   output logic                       busy
);

   logic [PORT_WIDTH-1:0] last_grant;
   logic [PORTS-1:0]      cand;
   logic [2*PORTS-1:0]    rot;
   logic [5:0]            off;
   logic [5:0]            idx;
   logic                  found;
   logic                  free;
   logic                  grant;
   logic [PORT_WIDTH-1:0] sel;
   logic [DEST_WIDTH-1:0] sel_dest;
   logic [31:0]           sel_len;

   // Rotating the doubled candidate vector puts last_grant+1 at bit 0,
   // so the lowest set bit is the next port in round-robin order.
   always_comb begin
      cand  = input_bd_valid & port_enable;
      rot   = {cand, cand} >> (6'(last_grant) + 6'd1);
      found = 1'b0;
      off   = '0;
      for (int j = PORTS - 1; j >= 0; j--) begin
         if (rot[j]) begin
            found = 1'b1;
            off   = 6'(j);
         end
      end
      idx = 6'(last_grant) + 6'd1 + off;
      if (idx >= 6'(PORTS)) begin
         idx = idx - 6'(PORTS);
      end
      sel      = PORT_WIDTH'(idx);
      sel_dest = input_bd_dest[sel*DEST_WIDTH +: DEST_WIDTH];
      sel_len  = input_bd_burst_len[sel*32 +: 32];
      free     = !output_bd_valid || output_bd_ready;
      grant    = !rst && free && found;
      input_bd_ready = '0;
      if (grant) begin
         input_bd_ready[sel] = 1'b1;
      end
      busy = output_bd_valid || (|cand);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         output_bd_valid     <= 1'b0;
         output_bd_dest      <= '0;
         output_bd_burst_len <= '0;
         output_bd_port      <= '0;
         last_grant          <= PORT_WIDTH'(PORTS - 1);
      end else if (free) begin
         output_bd_valid <= 1'b0;
         if (grant) begin
            last_grant <= sel;
            // Zero-length descriptors are accepted but never forwarded.
            if (sel_len != 32'd0) begin
               output_bd_valid     <= 1'b1;
               output_bd_dest      <= sel_dest;
               output_bd_burst_len <= sel_len;
               output_bd_port      <= sel;
            end
         end
      end
   end

endmodule

// File: tb/tb_fg_bd_arbiter.sv
// Bench for fg_bd_arbiter: directed scenarios plus randomized traffic
// compared against a descriptor-level round-robin reference model.
module tb_fg_bd_arbiter;

   localparam int P = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [31:0]  in_dest;
   logic [127:0] in_len;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_dest;
   logic [31:0]  out_len;
   logic [1:0]   out_port;
   logic [3:0]   en;
   logic         busy;

   int errors = 0;
   int checks = 0;

   bit          m_valid;
   logic [7:0]  m_dest;
   logic [31:0] m_len;
   logic [1:0]  m_port;
   int          m_last;

   fg_bd_arbiter #(.PORTS(4), .PORT_WIDTH(2), .DEST_WIDTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .input_bd_valid(in_valid),
      .input_bd_ready(in_ready),
      .input_bd_dest(in_dest),
      .input_bd_burst_len(in_len),
      .output_bd_valid(out_valid),
      .output_bd_ready(out_ready),
      .output_bd_dest(out_dest),
      .output_bd_burst_len(out_len),
      .output_bd_port(out_port),
      .port_enable(en),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int pick();
      for (int k = 1; k <= P; k++) begin
         int i;
         i = (m_last + k) % P;
         if (in_valid[i] && en[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_rdy();
      logic [3:0] r;
      int g;
      r = '0;
      g = pick();
      if (!rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic bit exp_busy();
      return m_valid || ((in_valid & en) != 4'd0);
   endfunction

   // Advance the reference model across one clock edge, then step past it.
   task automatic tick();
      int g;
      if (rst) begin
         m_valid = 0;
         m_dest  = '0;
         m_len   = '0;
         m_port  = '0;
         m_last  = P - 1;
      end else if (!m_valid || out_ready) begin
         g = pick();
         m_valid = 0;
         if (g >= 0) begin
            m_last = g;
            if (in_len[g*32 +: 32] != 32'd0) begin
               m_valid = 1;
               m_dest  = in_dest[g*8 +: 8];
               m_len   = in_len[g*32 +: 32];
               m_port  = 2'(g);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int i, input logic [7:0] d,
                           input logic [31:0] l);
      in_dest[i*8 +: 8]  = d;
      in_len[i*32 +: 32] = l;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 4'hf;
      en = 4'hf;
      out_ready = 1'b1;
      for (int i = 0; i < P; i++) set_port(i, 8'(i + 1), 32'd100);
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready: got %b want 0000", in_ready);
      end
      tick();
      tick();
      in_valid = 4'h0;
      #1;
      checks++;
      if ({out_valid, out_dest, out_len, out_port} !== 43'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b d=%h l=%0d p=%0d want zeros",
                  out_valid, out_dest, out_len, out_port);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      set_port(2, 8'h12, 32'd1500);
      in_valid = 4'b0100;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin
         errors++;
         $display("FAIL single_ready: got %b want 0100", in_ready);
      end
      tick();
      in_valid = 4'b0000;
      #1;
      checks++;
      if ({out_valid, out_dest, out_len, out_port} !==
          {1'b1, 8'h12, 32'd1500, 2'd2}) begin
         errors++;
         $display("FAIL single_out: got v=%b d=%h l=%0d p=%0d want 1 12 1500 2",
                  out_valid, out_dest, out_len, out_port);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got busy=%b v=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < P; i++) set_port(i, 8'(i), 32'(200 + i));
      in_valid = 4'hf;
      out_ready = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         #1;
         if (c > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_port !== 2'((c - 1) % P) ||
                out_dest !== 8'((c - 1) % P)) begin
               errors++;
               $display("FAIL rr_out[%0d]: got v=%b p=%0d d=%0d want 1 %0d",
                        c, out_valid, out_port, out_dest, (c - 1) % P);
            end
         end
         if (c < 6) begin
            checks++;
            if (in_ready !== 4'(1 << (c % P))) begin
               errors++;
               $display("FAIL rr_ready[%0d]: got %b want one-hot %0d",
                        c, in_ready, c % P);
            end
         end
         tick();
         if (c == 5) in_valid = 4'h0;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < P; i++) set_port(i, 8'(16 + i), 32'(300 + i));
      in_valid = 4'b0010;
      out_ready = 1'b0;
      tick();
      in_valid = 4'b1001;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_port !== 2'd1 ||
             out_dest !== 8'd17 || out_len !== 32'd301) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got r=%b v=%b p=%0d d=%0d l=%0d want 0000 1 1 17 301",
                     c, in_ready, out_valid, out_port, out_dest, out_len);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
         errors++;
         $display("FAIL bp_next3: got %b want 1000", in_ready);
      end
      tick();
      #1;
      checks++;
      if (out_port !== 2'd3 || in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL bp_then0: got p=%0d r=%b want 3 0001", out_port, in_ready);
      end
      tick();
      in_valid = 4'h0;
      checks++;
      if (out_port !== 2'd0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_out0: got p=%0d v=%b want 0 1", out_port, out_valid);
      end
      tick();
   endtask

   task automatic test_enable();
      logic [3:0] want;
      do_reset();
      for (int i = 0; i < P; i++) set_port(i, 8'(32 + i), 32'(64 * (i + 1)));
      en = 4'b1010;
      in_valid = 4'hf;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         want = (c % 2 == 0) ? 4'b0010 : 4'b1000;
         #1;
         checks++;
         if (in_ready !== want) begin
            errors++;
            $display("FAIL en_ready[%0d]: got %b want %b", c, in_ready, want);
         end
         tick();
      end
      en = 4'b1000;
      out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_port !== 2'd1 || in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL en_keep: got v=%b p=%0d r=%b want 1 1 0000",
                  out_valid, out_port, in_ready);
      end
      tick();
      out_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_port !== 2'(c == 0 ? 1 : 3) ||
             in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL en_masked[%0d]: got v=%b p=%0d r=%b want 1 %0d 1000",
                     c, out_valid, out_port, in_ready, c == 0 ? 1 : 3);
         end
         tick();
      end
      in_valid = 4'h0;
      en = 4'hf;
      tick();
   endtask

   task automatic test_zero_len();
      do_reset();
      set_port(0, 8'h40, 32'd0);
      set_port(1, 8'h41, 32'd64);
      set_port(2, 8'h42, 32'd77);
      set_port(3, 8'h43, 32'd88);
      out_ready = 1'b1;
      in_valid = 4'b0001;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL zl_ready0: got %b want 0001", in_ready);
      end
      tick();
      in_valid = 4'b0010;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0010) begin
         errors++;
         $display("FAIL zl_drop: got v=%b r=%b want 0 0010", out_valid, in_ready);
      end
      tick();
      in_valid = 4'b1111;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_port !== 2'd1 || out_len !== 32'd64 ||
          in_ready !== 4'b0100) begin
         errors++;
         $display("FAIL zl_out1: got v=%b p=%0d l=%0d r=%b want 1 1 64 0100",
                  out_valid, out_port, out_len, in_ready);
      end
      tick();
      in_valid = 4'h0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_port(2, 8'h22, 32'd500);
      for (int i = 0; i < P; i++) if (i != 2) set_port(i, 8'(i), 32'd10);
      in_valid = 4'b0100;
      out_ready = 1'b0;
      tick();
      rst = 1'b1;
      in_valid = 4'hf;
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL rm_during: got v=%b r=%b want 1 0000", out_valid, in_ready);
      end
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rm_after: got v=%b r=%b want 0 0001", out_valid, in_ready);
      end
      tick();
      in_valid = 4'h0;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom % 60) == 0;
         in_valid = 4'($urandom);
         en = ($urandom % 3 == 0) ? 4'($urandom) : 4'hf;
         out_ready = ($urandom % 4) != 0;
         for (int i = 0; i < P; i++)
            set_port(i, 8'($urandom),
                     ($urandom % 6 == 0) ? 32'd0 : 32'($urandom_range(1, 9000)));
         #1;
         checks++;
         if (in_ready !== exp_rdy()) begin
            errors++;
            $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, exp_rdy());
         end
         checks++;
         if (busy !== exp_busy() || out_valid !== m_valid) begin
            errors++;
            $display("FAIL rnd_state[%0d]: got busy=%b v=%b want %b %b",
                     c, busy, out_valid, exp_busy(), m_valid);
         end
         if (m_valid) begin
            checks++;
            if (out_dest !== m_dest || out_len !== m_len || out_port !== m_port) begin
               errors++;
               $display("FAIL rnd_fields[%0d]: got d=%h l=%0d p=%0d want %h %0d %0d",
                        c, out_dest, out_len, out_port, m_dest, m_len, m_port);
            end
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = '0;
      in_dest = '0;
      in_len = '0;
      out_ready = 1'b0;
      en = 4'hf;
      m_valid = 0;
      m_dest = '0;
      m_len = '0;
      m_port = '0;
      m_last = P - 1;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_enable();
      test_zero_len();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fg_bd_arbiter.md
# fg_bd_arbiter

Round-robin arbiter that merges burst descriptor streams from several flow sources into the single burst descriptor input of the flow generator's packet generator. Each source presents a descriptor of destination plus burst length. The arbiter grants one enabled source per accepted output slot and registers the winning descriptor, tagged with the source port number. It sits between the per-flow descriptor sources and `fg_packet_gen`, and its output maps directly onto that block's `input_bd_*` ports.

## Interface
- `PORTS`, 4: number of descriptor sources (2..16).
- `PORT_WIDTH`, 2: width of the port tag; must satisfy 2^PORT_WIDTH >= PORTS.
- `DEST_WIDTH`, 8: width of the destination field.
- `clk` in 1: clock; all logic runs on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `input_bd_valid` in PORTS: per-source descriptor valid.
- `input_bd_ready` out PORTS: per-source accept; at most one bit high per cycle.
- `input_bd_dest` in PORTS*DEST_WIDTH: per-source destination; port i occupies bits [i*DEST_WIDTH +: DEST_WIDTH].
- `input_bd_burst_len` in PORTS*32: per-source burst length in bytes; port i occupies bits [i*32 +: 32].
- `output_bd_valid` out 1: registered descriptor valid.
- `output_bd_ready` in 1: downstream accept.
- `output_bd_dest` out DEST_WIDTH: granted destination.
- `output_bd_burst_len` out 32: granted burst length.
- `output_bd_port` out PORT_WIDTH: index of the source that supplied the descriptor.
- `port_enable` in PORTS: configuration input; a port whose bit is low is never granted.
- `busy` out 1: high when `output_bd_valid` is high or any enabled port has `input_bd_valid` high.

## Operation
- One output register holds a single descriptor. The register is free when `output_bd_valid` is 0, or when `output_bd_valid` and `output_bd_ready` are both 1 in the current cycle.
- Candidate set: ports with `input_bd_valid[i] & port_enable[i]`.
- Selection order: the first candidate found scanning from `last_grant+1` upward, wrapping from PORTS-1 to 0. `last_grant` itself is checked last.
- Grant: when the register is free and the candidate set is non-empty, `input_bd_ready` is driven high for the selected port only, in the same cycle. `input_bd_ready` is a combinational function of the current-cycle inputs and state.
- On the grant edge:
  - `last_grant` takes the granted index.
  - If `burst_len` is non-zero, the register loads dest, burst_len and port, and `output_bd_valid` becomes 1.
  - If `burst_len` is 0, the descriptor is consumed and dropped. `output_bd_valid` becomes 0 if the register was being emptied, otherwise it is unchanged.
- If the register is free with no candidates, or is being emptied with no new grant, `output_bd_valid` goes to 0 at the edge.
- While `output_bd_valid` is 1 and `output_bd_ready` is 0, all `input_bd_ready` bits are 0 and all output fields stay stable.
- `port_enable` changes take effect in the same cycle. Disabling a port never retracts a descriptor already in the register.
- Port indices at or above PORTS never appear on `output_bd_port`.

## Timing
- Reset values: `output_bd_valid` 0, `output_bd_dest` 0, `output_bd_burst_len` 0, `output_bd_port` 0, `input_bd_ready` all 0 while `rst` is high, `last_grant` PORTS-1 (so port 0 has first priority), `busy` as its combinational definition from the post-reset state.
- Reset mid-operation: any descriptor held in the register is discarded. No `input_bd_ready` is asserted during the reset cycle.
- Latency: the input handshake at edge N puts `output_bd_valid` high after edge N.
- Throughput: one descriptor per cycle when `output_bd_ready` is held high. Back-to-back grants are allowed because accept and reload happen on the same edge.
- Fairness: with all ports continuously valid and enabled, the grant sequence is 0,1,...,PORTS-1,0,... with no port skipped.

## Test plan
- Single port: reset, then port 2 presents dest=0x12, len=1500 with `output_bd_ready`=1 -> `input_bd_ready`=0b0100 for one cycle; the next cycle shows valid=1, dest=0x12, len=1500, port=2. `busy` falls after the output is accepted.
- Full round-robin: all 4 ports valid, each port's dest equal to its index, ready=1 -> output ports 0,1,2,3,0,1 on consecutive cycles; `input_bd_ready` is one-hot every cycle.
- Backpressure: the output holds port 1's descriptor and `output_bd_ready`=0 for 5 cycles while ports 0 and 3 are valid -> `input_bd_ready`=0 and outputs stable for those cycles. When ready rises, the next grant is port 3, then port 0.
- Enable masking: `port_enable`=0b1010 with all ports valid -> only ports 1 and 3 are granted, alternating. Clearing bit 1 while port 1's descriptor is in the register -> that descriptor is still delivered, then only port 3 is granted.
- Zero-length drop: port 0 presents len=0, then port 1 presents len=64 -> port 0's ready pulses with no output. The only output descriptor is port 1's, len=64, and the next scan starts at port 2.
- Reset mid-burst: `rst` asserted for 1 cycle while `output_bd_valid`=1 -> valid is 0 after that edge, no ready is asserted during reset, and the next grant scans from port 0.
